// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
// rr_pick gives the round-robin winner index for a request vector and pointer.
package dpram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_LAT  = 1;
  localparam int MAX_REQ     = 32;

  // First valid index strictly after ptr, wrapping; 0 when nothing is valid.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !found && valid[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from a request vector plus the
// last-winner pointer, updated only when the owner accepts the grant.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 upd,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0]    ptr;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    gnt_id         = ID_W'(rr_pick(req_ext, int'(ptr), N));
    gnt            = '0;
    if (|req) gnt[gnt_id] = 1'b1;
  end

  // Pointer starts at N-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) ptr <= ID_W'(N - 1);
    else if (upd && |req) ptr <= gnt_id;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one RAM port among NUM_REQ requesters, one transaction at a time,
// returning read data after the fixed RAM read latency.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_q,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e         state, state_nx;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win_id;
  logic               take;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [ID_W-1:0]    lat_id;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rdata;

  assign take = (state == IDLE) && (|req_valid) && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .upd    (take),
    .gnt    (gnt),
    .gnt_id (win_id)
  );

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (take) begin
          req_ready = gnt;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (mem_ready) state_nx = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
      end
      RESP: begin
        rsp_valid[lat_id] = 1'b1;
        rsp_rdata         = rdata;
        state_nx          = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign grant_id = lat_id;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // rdata is cleared at the RAM handshake so a write responds with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      if (take) begin
        lat_we    <= req_we[win_id];
        lat_addr  <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
        lat_wdata <= req_wdata[int'(win_id)*DATA_W +: DATA_W];
        lat_id    <= win_id;
      end
      if (state == ISSUE && mem_ready) begin
        cnt   <= CNT_W'(RD_LAT - 1);
        rdata <= '0;
      end
      if (state == WAIT) begin
        if (cnt == '0) rdata <= mem_q;
        else           cnt   <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Testbench for dpram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (RR order, RAM contents, latency).
module tb_dpram_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, mem_wdata, mem_q;
  logic                      mem_valid, mem_ready, mem_we, busy;
  logic [ADDR_W-1:0]         mem_addr;
  logic [1:0]                grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_rdy    = 0;
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  logic [7:0] pipe [RD_LAT];

  dpram_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_q(mem_q), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM with RD_LAT-cycle read pipeline; idle slots carry zero.
  always @(posedge clk) begin
    if (mem_valid && mem_ready && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_valid && mem_ready && !mem_we) ? ram[mem_addr] : 8'h00;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[RD_LAT-1];

  function automatic int exp_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_req(input int id, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_addr[id*ADDR_W +: ADDR_W]  = a;
    req_wdata[id*DATA_W +: DATA_W] = d;
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = '0; mem_ready = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(output logic [3:0] g);
    int k;
    k = 0;
    #1;
    while (req_ready == '0 && k < 40) begin @(negedge clk); #1; k++; end
    g = req_ready;
    t_rdy = cyc;
  endtask

  task automatic wait_rsp(output logic [3:0] v, output logic [7:0] d, output int lat);
    int k;
    k = 0; v = '0; d = '0; lat = -1;
    #1;
    while (rsp_valid == '0 && k < 40) begin @(negedge clk); #1; k++; end
    if (rsp_valid != '0) begin v = rsp_valid; d = rsp_rdata; lat = cyc - t_rdy; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [3:0] g, v; logic [7:0] d; int lat;
    set_req(2, 1'b1, 8'h10, 8'hA5);
    wait_ready(g);
    ref_mem[8'h10] = 8'hA5;
    n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL wr_grant got %b want 0100", g); end
    @(negedge clk); req_valid = '0;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b0100 || d !== 8'h00 || lat != 2)
      begin n_fail++; $display("FAIL wr_rsp got v=%b d=%h lat=%0d want 0100/00/2", v, d, lat); end
    @(negedge clk);
    set_req(2, 1'b0, 8'h10, 8'h00);
    wait_ready(g);
    n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL rd_grant got %b want 0100", g); end
    @(negedge clk); req_valid = '0;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b0100 || d !== 8'hA5 || lat != 2 + RD_LAT)
      begin n_fail++; $display("FAIL rd_rsp got v=%b d=%h lat=%0d want 0100/a5/%0d", v, d, lat, 2 + RD_LAT); end
  endtask

  task automatic test_all_valid();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    int g_cnt, p_id, last_t, last_gap, id;
    logic pend, p_we;
    logic [7:0] p_a, p_d, p_exp;
    logic [3:0] regen;
    apply_reset(2);
    g_cnt = 0; pend = 1'b0; last_t = -1; last_gap = 0; regen = '1;
    p_id = 0; p_we = 1'b0; p_a = '0; p_d = '0; p_exp = '0;
    for (int c = 0; c < 120 && (g_cnt < 6 || pend); c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (regen[i]) begin set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom)); regen[i] = 1'b0; end
      #1;
      if (pend && mem_valid) begin
        n_checks++;
        if (mem_addr !== p_a || mem_we !== p_we || (p_we && mem_wdata !== p_d))
          begin n_fail++; $display("FAIL av_mem got a=%h we=%b d=%h want a=%h we=%b d=%h", mem_addr, mem_we, mem_wdata, p_a, p_we, p_d); end
      end
      if (rsp_valid !== '0) begin
        n_checks++;
        if (!pend || rsp_valid !== 4'(1 << p_id) || rsp_rdata !== p_exp || grant_id !== 2'(p_id))
          begin n_fail++; $display("FAIL av_rsp got v=%b d=%h id=%0d want v=%b d=%h", rsp_valid, rsp_rdata, grant_id, 4'(1 << p_id), p_exp); end
        pend = 1'b0;
      end
      if (req_ready !== '0) begin
        id = (g_cnt < 6) ? exp_seq[g_cnt] : 0;
        n_checks++;
        if (g_cnt >= 6 || req_ready !== 4'(1 << id))
          begin n_fail++; $display("FAIL av_grant#%0d got %b want %b", g_cnt, req_ready, 4'(1 << id)); end
        if (last_t >= 0) begin
          n_checks++;
          if (cyc - last_t != last_gap)
            begin n_fail++; $display("FAIL av_gap got %0d want %0d", cyc - last_t, last_gap); end
        end
        p_id = id; p_we = req_we[id]; p_a = req_addr[id*ADDR_W +: ADDR_W]; p_d = req_wdata[id*DATA_W +: DATA_W];
        p_exp = p_we ? 8'h00 : ref_mem[p_a];
        if (p_we) ref_mem[p_a] = p_d;
        regen[id] = 1'b1; pend = 1'b1; g_cnt++; last_t = cyc; last_gap = p_we ? 3 : 3 + RD_LAT;
      end
    end
    req_valid = '0;
    n_checks++; if (g_cnt < 6 || pend) begin n_fail++; $display("FAIL av_timeout grants=%0d want 6", g_cnt); end
  endtask

  task automatic test_stall();
    logic [3:0] g, v; logic [7:0] d; int lat;
    @(negedge clk);
    set_req(0, 1'b0, 8'h10, 8'h5A);
    mem_ready = 1'b0;
    wait_ready(g);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL st_grant got %b want 0001", g); end
    for (int s = 0; s < 7; s++) begin
      @(negedge clk); req_valid = '0; #1;
      n_checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 8'h10 || mem_we !== 1'b0 || mem_wdata !== 8'h5A)
        begin n_fail++; $display("FAIL st_hold%0d got v=%b a=%h we=%b d=%h want 1/10/0/5a", s, mem_valid, mem_addr, mem_we, mem_wdata); end
    end
    @(negedge clk); mem_ready = 1'b1;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b0001 || d !== ref_mem[8'h10] || lat != 2 + RD_LAT + 7)
      begin n_fail++; $display("FAIL st_rsp got v=%b d=%h lat=%0d want 0001/%h/%0d", v, d, lat, ref_mem[8'h10], 2 + RD_LAT + 7); end
  endtask

  task automatic test_fairness();
    logic [3:0] g, v; logic [7:0] d; int lat;
    @(negedge clk);
    set_req(3, 1'b0, 8'h01, 8'h00);
    wait_ready(g);
    n_checks++; if (g !== 4'b1000) begin n_fail++; $display("FAIL fr_first got %b want 1000", g); end
    @(negedge clk); req_valid = '0;
    wait_rsp(v, d, lat);
    @(negedge clk);
    set_req(1, 1'b0, 8'h02, 8'h00);
    set_req(3, 1'b0, 8'h03, 8'h00);
    wait_ready(g);
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL fr_wrap got %b want 0010", g); end
    @(negedge clk); req_valid[1] = 1'b0;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b0010) begin n_fail++; $display("FAIL fr_rsp1 got %b want 0010", v); end
    set_req(1, 1'b0, 8'h04, 8'h00);
    wait_ready(g);
    n_checks++; if (g !== 4'b1000) begin n_fail++; $display("FAIL fr_fair got %b want 1000", g); end
    @(negedge clk); req_valid[3] = 1'b0;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b1000) begin n_fail++; $display("FAIL fr_rsp3 got %b want 1000", v); end
    req_valid = '0;
  endtask

  task automatic test_lat_ff();
    logic [3:0] g, v; logic [7:0] d; int lat;
    @(negedge clk);
    set_req(3, 1'b0, 8'hFF, 8'h00);
    wait_ready(g);
    @(negedge clk); req_valid = '0;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b1000 || d !== 8'h3C || lat != 2 + RD_LAT)
      begin n_fail++; $display("FAIL ff_rsp got v=%b d=%h lat=%0d want 1000/3c/%0d", v, d, lat, 2 + RD_LAT); end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] g, v, seen; logic [7:0] d; int lat;
    @(negedge clk);
    set_req(1, 1'b0, 8'h20, 8'h00);
    wait_ready(g);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b1 || mem_valid !== 1'b0)
      begin n_fail++; $display("FAIL rm_wait got busy=%b mem_valid=%b want 1/0", busy, mem_valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = '0;
    repeat (6) begin #1; seen = seen | rsp_valid; @(negedge clk); end
    n_checks++; if (seen !== '0) begin n_fail++; $display("FAIL rm_dropped got rsp %b want 0", seen); end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 8'(i), 8'h00);
    wait_ready(g);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL rm_regrant got %b want 0001", g); end
    @(negedge clk); req_valid = '0;
    wait_rsp(v, d, lat);
    n_checks++; if (v !== 4'b0001) begin n_fail++; $display("FAIL rm_rsp got %b want 0001", v); end
  endtask

  task automatic test_random();
    int ptr, grants, stalls, p_id, e;
    logic pend, p_we;
    logic [7:0] p_a, p_d, p_exp;
    logic [3:0] drop;
    apply_reset(2);
    ptr = NUM_REQ - 1; grants = 0; stalls = 0; pend = 1'b0; drop = '0;
    p_id = 0; p_we = 1'b0; p_a = '0; p_d = '0; p_exp = '0;
    for (int c = 0; c < 4000 && grants < 150; c++) begin
      if (c > 0) @(negedge clk);
      mem_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drop[i]) begin req_valid[i] = 1'b0; drop[i] = 1'b0; end
        else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        end else if (!pend && $urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
      end
      #1;
      if (pend && mem_valid) begin
        if (!mem_ready) stalls++;
        n_checks++;
        if (mem_addr !== p_a || mem_we !== p_we || (p_we && mem_wdata !== p_d))
          begin n_fail++; $display("FAIL rnd_mem got a=%h we=%b d=%h want a=%h we=%b d=%h", mem_addr, mem_we, mem_wdata, p_a, p_we, p_d); end
      end
      n_checks++;
      if (!pend) begin
        e = exp_pick(req_valid, ptr);
        if (req_ready !== ((e < 0) ? 4'b0000 : 4'(1 << e)))
          begin n_fail++; $display("FAIL rnd_grant got %b valid=%b ptr=%0d want idx %0d", req_ready, req_valid, ptr, e); end
        if (e >= 0) begin
          p_id = e; p_we = req_we[e]; p_a = req_addr[e*ADDR_W +: ADDR_W]; p_d = req_wdata[e*DATA_W +: DATA_W];
          p_exp = p_we ? 8'h00 : ref_mem[p_a];
          if (p_we) ref_mem[p_a] = p_d;
          ptr = e; pend = 1'b1; stalls = 0; grants++; drop[e] = 1'b1; t_rdy = cyc;
        end
      end else if (req_ready !== '0) begin
        n_fail++; $display("FAIL rnd_busy_ready got %b want 0", req_ready);
      end
      if (rsp_valid !== '0) begin
        n_checks++;
        if (!pend || rsp_valid !== 4'(1 << p_id) || rsp_rdata !== p_exp ||
            cyc - t_rdy != (p_we ? 2 : 2 + RD_LAT) + stalls)
          begin n_fail++; $display("FAIL rnd_rsp got v=%b d=%h lat=%0d want v=%b d=%h lat=%0d", rsp_valid, rsp_rdata, cyc - t_rdy, 4'(1 << p_id), p_exp, (p_we ? 2 : 2 + RD_LAT) + stalls); end
        pend = 1'b0;
      end
    end
    req_valid = '0;
    n_checks++; if (grants < 150) begin n_fail++; $display("FAIL rnd_timeout grants=%0d want 150", grants); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 8'($urandom); ref_mem[i] = ram[i]; end
    ram[255] = 8'h3C; ref_mem[255] = 8'h3C;
    for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
    test_reset();
    test_write_read();
    test_all_valid();
    test_stall();
    test_fairness();
    test_lat_ff();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
